conv_frame_sequencer: RTL and testbench

Frame-level controller placed in front of the streaming convolution datapath. Loads kernel weights serially, then admits exactly one frame of pixels from a valid/ready upstream source. It counts the datapath's result strobes until the frame is complete and forwards results with a last marker. The datapath has no backpressure, so this block is the only place where frames are gated, bounded and aborted.

---
 rtl/conv_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_conv_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the streaming convolution datapath: serial weight load,
// one gated pixel frame, result counting with last marker, drain timeout and abort.
module conv_frame_sequencer #(
    parameter int Kernal_Dim    = 2,
    parameter int Kernal_Ch     = 3,
    parameter int Img_Dim       = 4,
    parameter int Img_Ch        = 3,
    parameter int Out_Dim       = 2,
    parameter int Drain_Timeout = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     reuse_weights,
    input  logic                                     abort,
    input  logic [7:0]                               wt_data,
    input  logic                                     wt_valid,
    output logic                                     wt_ready,
    input  logic [7:0]                               pix_data,
    input  logic                                     pix_valid,
    output logic                                     pix_ready,
    output logic [7:0]                               conv_in_stream,
    output logic                                     conv_in_valid,
    output logic [Kernal_Dim*Kernal_Dim*Kernal_Ch*8-1:0] kernel_weights,
    output logic                                     conv_rst,
    input  logic [15:0]                              conv_out_data,
    input  logic                                     conv_out_valid,
    output logic [15:0]                              res_data,
    output logic                                     res_valid,
    output logic                                     res_last,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic                                     error,
    output logic [15:0]                              frame_count
);

    localparam int NumW   = Kernal_Dim * Kernal_Dim * Kernal_Ch;
    localparam int NumPix = Img_Dim * Img_Dim * Img_Ch;
    localparam int NumRes = Out_Dim * Out_Dim;
    localparam int WW     = $clog2(NumW + 1);
    localparam int PW     = $clog2(NumPix + 1);
    localparam int RW     = $clog2(NumRes + 1);
    localparam int TW     = $clog2(Drain_Timeout + 1);

    localparam logic [WW-1:0] WLast   = WW'(NumW - 1);
    localparam logic [PW-1:0] PLast   = PW'(NumPix - 1);
    localparam logic [PW-1:0] PFull   = PW'(NumPix);
    localparam logic [RW-1:0] RLast   = RW'(NumRes - 1);
    localparam logic [RW-1:0] RFull   = RW'(NumRes);
    localparam logic [TW-1:0] TLast   = TW'(Drain_Timeout - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt;
    logic [PW-1:0] pcnt;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tcnt;
    logic          abort_take, wt_take, pix_take, res_take, res_final;
    logic          drain_full, timeout;

    // NOTE: every output of always_comb gets a default first so no path can infer a latch.
    always_comb begin
        abort_take = abort && (state != IDLE);
        wt_ready   = (state == LOAD_W);
        pix_ready  = (state == STREAM) && (pcnt != PFull);
        wt_take    = wt_valid && wt_ready;
        pix_take   = pix_valid && pix_ready;
        res_take   = conv_out_valid && ((state == STREAM) || (state == DRAIN)) &&
                     (rcnt != RFull) && !abort_take;
        res_final  = res_take && (rcnt == RLast);
        drain_full = (rcnt == RFull) || res_final;
        timeout    = (tcnt == TLast) && !drain_full;
        state_nxt  = state;
        case (state)
            IDLE:    if (start) state_nxt = reuse_weights ? STREAM : LOAD_W;
            LOAD_W:  if (wt_take && (wcnt == WLast)) state_nxt = STREAM;
            STREAM:  if (pix_take && (pcnt == PLast)) state_nxt = DRAIN;
            DRAIN:   if (drain_full || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_take) state_nxt = IDLE;
    end

    assign conv_in_stream = pix_data;
    assign conv_in_valid  = pix_take;
    assign busy           = (state != IDLE);
    assign frame_done     = (state == DONE) && !abort;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            wcnt           <= '0;
            pcnt           <= '0;
            rcnt           <= '0;
            tcnt           <= '0;
            // NOTE: the weight store is reset because kernel_weights must read 0 out of reset.
            kernel_weights <= '0;
            conv_rst       <= 1'b0;
            res_data       <= '0;
            res_valid      <= 1'b0;
            res_last       <= 1'b0;
            error          <= 1'b0;
            frame_count    <= '0;
        end else begin
            state     <= state_nxt;
            conv_rst  <= !abort_take;
            res_valid <= res_take;
            res_last  <= res_final;
            if (res_take) begin
                res_data <= conv_out_data;
                rcnt     <= rcnt + RW'(1);
            end
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    pcnt <= '0;
                    rcnt <= '0;
                    tcnt <= '0;
                    if (start) error <= 1'b0;
                end
                LOAD_W: if (wt_take) begin
                    kernel_weights[int'(wcnt)*8 +: 8] <= wt_data;
                    wcnt <= wcnt + WW'(1);
                end
                STREAM: if (pix_take) pcnt <= pcnt + PW'(1);
                DRAIN: begin
                    tcnt <= tcnt + TW'(1);
                    if (timeout && !abort_take) error <= 1'b1;
                end
                DONE: if (!abort_take) frame_count <= frame_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer: weight load, pixel gating,
// result forwarding/latency, drain timeout, abort and mid-frame reset.
module tb_conv_frame_sequencer;

    localparam int NW = 12;
    localparam int NP = 48;
    localparam int KW = NW * 8;

    logic          clk = 1'b0;
    logic          rst, start, reuse_weights, abort;
    logic [7:0]    wt_data, pix_data;
    logic          wt_valid, wt_ready, pix_valid, pix_ready;
    logic [7:0]    conv_in_stream;
    logic          conv_in_valid;
    logic [KW-1:0] kernel_weights;
    logic          conv_rst;
    logic [15:0]   conv_out_data;
    logic          conv_out_valid;
    logic [15:0]   res_data;
    logic          res_valid, res_last, busy, frame_done, error;
    logic [15:0]   frame_count;

    conv_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .reuse_weights(reuse_weights), .abort(abort),
        .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .conv_in_stream(conv_in_stream), .conv_in_valid(conv_in_valid),
        .kernel_weights(kernel_weights), .conv_rst(conv_rst),
        .conv_out_data(conv_out_data), .conv_out_valid(conv_out_valid),
        .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
        .busy(busy), .frame_done(frame_done), .error(error), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e_mon;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_last = 0;
    bit            wt_seen = 1'b0;
    logic [KW-1:0] exp_kw = '0;
    int            taken, obs, dcyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wt_ready) wt_seen = 1'b1;
        if (rst && res_valid) begin
            if (exp_q.size() == 0) begin
                check("res_unexpected", res_data, 16'hxxxx);
            end else begin
                e_mon = exp_q.pop_front();
                check("res_data", res_data, e_mon.data);
                check("res_last", res_last, e_mon.last);
                check("res_latency", cyc, e_mon.cyc);
            end
            if (res_last) n_last++;
        end
    end

    task automatic emit(input logic [15:0] d, input bit counted, input bit last);
        conv_out_valid = 1'b1;
        conv_out_data  = d;
        if (counted) exp_q.push_back('{d, last, cyc + 1});
        step();
        conv_out_valid = 1'b0;
    endtask

    task automatic start_frame(input bit reuse);
        start = 1'b1;
        reuse_weights = reuse;
        wt_seen = 1'b0;
        step();
        start = 1'b0;
        reuse_weights = 1'b0;
        check("start_busy", busy, 1);
        check("start_wt_ready", wt_ready, !reuse);
        check("start_error_clr", error, 0);
    endtask

    task automatic load_weights(input logic [7:0] base);
        for (int i = 0; i < NW; i++) begin
            wt_valid = 1'b1;
            wt_data  = base + 8'(i);
            exp_kw[8*i +: 8] = base + 8'(i);
            #1;
            check("wt_ready_load", wt_ready, 1);
            step();
        end
        wt_valid = 1'b0;
        check("wt_ready_after", wt_ready, 0);
        check("pix_ready_after_load", pix_ready, 1);
    endtask

    // Drives pixels until 'target' are accepted; optionally one result strobe at beat res_at.
    task automatic stream(input int target, input bit gap, input bit ones, input int res_at,
                          output int acc, output int seen);
        int  beat = 0;
        logic exp_v;
        acc  = 0;
        seen = 0;
        while (acc < target && beat < 300) begin
            pix_valid = !gap || (beat % 2 == 0);
            pix_data  = ones ? 8'd1 : 8'($urandom_range(0, 255));
            if (beat == res_at) begin
                conv_out_valid = 1'b1;
                conv_out_data  = 16'h0c00 + 16'(beat);
                exp_q.push_back('{16'h0c00 + 16'(beat), 1'b0, cyc + 1});
            end else begin
                conv_out_valid = 1'b0;
            end
            #1;
            exp_v = pix_valid && (acc < NP);
            check("pix_accept", conv_in_valid, exp_v);
            check("pix_pass", conv_in_stream, pix_data);
            if (exp_v) acc++;
            if (conv_in_valid) seen++;
            @(posedge clk);
            #1;
            beat++;
        end
        pix_valid = 1'b0;
        conv_out_valid = 1'b0;
        if (beat >= 300) check("pix_bound", acc, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; reuse_weights = 1'b0; abort = 1'b0;
        wt_data = '0; wt_valid = 1'b0; pix_data = '0; pix_valid = 1'b0;
        conv_out_data = '0; conv_out_valid = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_conv_rst", conv_rst, 0);
        check("rst_kw", kernel_weights, 0);
        check("rst_count", frame_count, 0);
        check("rst_error", error, 0);
        check("rst_ready", {wt_ready, pix_ready, res_valid, frame_done}, 0);
        rst = 1'b1;
        step();
        check("rel_conv_rst", conv_rst, 1);

        // Strobe in IDLE is dropped.
        emit(16'hbeef, 1'b0, 1'b0);
        step();

        // Frame 1: weights 1..12, 48 ones, 4 results of 78.
        start_frame(1'b0);
        load_weights(8'd1);
        stream(NP, 1'b0, 1'b1, -1, taken, obs);
        check("f1_pixels", obs, NP);
        check("f1_kw", kernel_weights, exp_kw);
        check("f1_kw_el11", kernel_weights[95:88], 8'd12);
        for (int i = 0; i < 4; i++) emit(16'd78, 1'b1, i == 3);
        check("f1_done", frame_done, 1);
        check("f1_count_pre", frame_count, 0);
        step();
        check("f1_done_pulse", frame_done, 0);
        check("f1_idle", busy, 0);
        check("f1_count", frame_count, 1);
        check("f1_last", n_last, 1);

        // Frame 2: reuse weights, toggled pix_valid, one result during STREAM.
        start_frame(1'b1);
        stream(NP, 1'b1, 1'b0, 10, taken, obs);
        check("f2_pixels", obs, NP);
        pix_valid = 1'b1;
        #1;
        check("f2_pix49_ready", pix_ready, 0);
        check("f2_pix49_valid", conv_in_valid, 0);
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) emit(16'h2000 + 16'(i), 1'b1, i == 2);
        check("f2_done", frame_done, 1);
        emit(16'hdead, 1'b0, 1'b0);
        check("f2_count", frame_count, 2);
        check("f2_no_wt_ready", wt_seen, 0);
        check("f2_kw_kept", kernel_weights, exp_kw);
        check("f2_last", n_last, 2);

        // Frame 3: new weights, only 3 results -> drain timeout.
        start_frame(1'b0);
        load_weights(8'ha0);
        stream(NP, 1'b0, 1'b0, -1, taken, obs);
        for (int i = 0; i < 3; i++) emit(16'h3000 + 16'(i), 1'b1, 1'b0);
        dcyc = 3;
        while (!frame_done && dcyc < 200) begin
            step();
            dcyc++;
        end
        check("f3_timeout_cycles", dcyc, 64);
        check("f3_error", error, 1);
        check("f3_kw", kernel_weights, exp_kw);
        step();
        check("f3_count", frame_count, 3);
        check("f3_error_sticky", error, 1);
        check("f3_idle", busy, 0);

        // Frame 4: abort at pixel 20.
        start_frame(1'b1);
        stream(20, 1'b0, 1'b0, -1, taken, obs);
        check("f4_pixels", obs, 20);
        check("f4_conv_rst_pre", conv_rst, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("f4_idle", busy, 0);
        check("f4_conv_rst_low", conv_rst, 0);
        check("f4_no_done", frame_done, 0);
        step();
        check("f4_conv_rst_high", conv_rst, 1);
        check("f4_count", frame_count, 3);
        check("f4_last", n_last, 2);
        check("f4_kw", kernel_weights, exp_kw);

        // Frame 5: reset mid-DRAIN.
        start_frame(1'b1);
        stream(NP, 1'b0, 1'b0, -1, taken, obs);
        emit(16'h1234, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("r5_busy", busy, 0);
        check("r5_conv_rst", conv_rst, 0);
        check("r5_kw", kernel_weights, 0);
        check("r5_count", frame_count, 0);
        check("r5_error", error, 0);
        check("r5_res", {res_valid, res_last, res_data}, 0);
        check("r5_ready", {wt_ready, pix_ready, conv_in_valid, frame_done}, 0);
        rst = 1'b1;
        step();
        check("r5_conv_rst_rel", conv_rst, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
